// File: rtl/fnd_count_ctrl.sv
// fnd_count_ctrl: button-driven run/stop/clear up/down counter for the FND display path.
// Buttons pass through a 2-flop synchronizer, an optional debouncer, and a rising-edge
// detector. A STOP/RUN/CLEAR FSM gates a prescaler that strobes the wrap-around counter.
// Optional feature: define FND_CNT_DEBOUNCE_EN to insert a DB_CYCLES-cycle debouncer.
module fnd_count_ctrl #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 10,
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned COUNT_MAX = 511
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_clear,
  input  logic       btn_mode,
  output logic [8:0] counter,
  output logic       o_run,
  output logic       o_dir
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [8:0]    CMAX     = 9'(COUNT_MAX);

  // Elaboration-time guard on the parameter ranges the design relies on.
  if (DIV < 2 || COUNT_MAX < 1 || COUNT_MAX > 511 || DB_CYCLES < 1) begin : g_param_check
    $error("fnd_count_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_CLEAR
  } state_t;

  state_t state, state_nxt;

  // Bit 0 = run, bit 1 = clear, bit 2 = mode.
  logic [2:0] btn_raw;
  logic [2:0] sync1, sync2;
  logic [2:0] level, level_q, pulse;
  logic       p_run, p_clear, p_mode;

  logic [PW-1:0] presc, presc_nxt;
  logic          tick;
  logic [8:0]    count_nxt;

  assign btn_raw = {btn_mode, btn_clear, btn_run};

  // Two-flop synchronizer for the asynchronous buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef FND_CNT_DEBOUNCE_EN
  localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic [DBW-1:0] db_cnt [3];
  logic [2:0]     db_level;

  // Accept a new level only after DB_CYCLES consecutive samples disagree with the current one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_level <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= sync2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign level = db_level;
`else
  assign level = sync2;
`endif

  // Registered rising-edge detect; a held button after reset still yields one pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= '0;
      pulse   <= '0;
    end else begin
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

  assign p_run   = pulse[0];
  assign p_clear = pulse[1];
  assign p_mode  = pulse[2];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_STOP;
    else        state <= state_nxt;
  end

  // Next-state logic: clear beats run in STOP, clear ignored in RUN, CLEAR lasts one cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_STOP: begin
        if (p_clear)    state_nxt = ST_CLEAR;
        else if (p_run) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (p_run) state_nxt = ST_STOP;
      end
      ST_CLEAR: state_nxt = ST_STOP;
      default:  state_nxt = ST_STOP;
    endcase
  end

  assign o_run = (state == ST_RUN);
  assign tick  = (state == ST_RUN) && (presc == PRE_LAST);

  // Prescaler and counter next values; the prescaler holds in STOP so a resumed run finishes its period.
  always_comb begin
    presc_nxt = presc;
    count_nxt = counter;
    if (state == ST_CLEAR) begin
      presc_nxt = '0;
      count_nxt = '0;
    end else if (state == ST_RUN) begin
      presc_nxt = (presc == PRE_LAST) ? '0 : presc + 1'b1;
      if (tick) begin
        if (o_dir) count_nxt = (counter == '0) ? CMAX : counter - 9'd1;
        else       count_nxt = (counter == CMAX) ? '0 : counter + 9'd1;
      end
    end
  end

  // Datapath registers; direction toggles on the mode pulse regardless of state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc   <= '0;
      counter <= '0;
      o_dir   <= 1'b0;
    end else begin
      presc   <= presc_nxt;
      counter <= count_nxt;
      if (p_mode) o_dir <= ~o_dir;
    end
  end

endmodule
